// File: rtl/vmode_pkg.sv
// Shared types and helpers for the palette mode sequencer.
package vmode_pkg;

  localparam int unsigned VMODE_W           = 4;
  localparam int unsigned NUM_MODES_DEFAULT = 11;

  typedef enum logic [VMODE_W-1:0] {
    MONO     = 4'd0,
    GREY     = 4'd1,
    RGB1     = 4'd2,
    RGB2     = 4'd3,
    FIELD    = 4'd4,
    ICE      = 4'd5,
    XMAS     = 4'd6,
    MARKSMAN = 4'd7,
    VEGAS    = 4'd8,
    AY8515   = 4'd9,
    TRQ      = 4'd10
  } vmode_e;

  typedef enum logic {
    DIR_PREV = 1'b0,
    DIR_NEXT = 1'b1
  } dir_e;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } req_state_e;

  // One step forward or backward through 0 .. num_modes-1 with wrap-around.
  function automatic logic [VMODE_W-1:0] step_mode(
    input logic [VMODE_W-1:0] mode,
    input dir_e               dir,
    input int unsigned        num_modes
  );
    logic [VMODE_W-1:0] last;
    last = VMODE_W'(num_modes - 1);
    if (dir == DIR_NEXT) begin
      return (mode == last) ? '0 : VMODE_W'(mode + 1);
    end
    return (mode == '0) ? last : VMODE_W'(mode - 1);
  endfunction

endpackage

// File: rtl/vmode_button.sv
// One front-panel button: synchroniser, debounce, press edge and
// frame-based auto-repeat, producing a one-cycle step event.
module vmode_button #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_FRAMES   = 30
) (
  input  logic clkvideo,
  input  logic rst_n,
  input  logic btn,
  input  logic frame_tick,
  output logic step
);

  localparam int unsigned DB_W  = 20;
  localparam int unsigned RPT_W = 8;

  logic             btn_meta;
  logic             btn_sync;
  logic             level;
  logic             level_d;
  logic [DB_W-1:0]  db_cnt;
  logic [RPT_W-1:0] rpt_cnt;
  logic             rise;
  logic             rpt_hit;

  // Press edge and repeat expiry for this cycle.
  always_comb begin
    rise    = level & ~level_d;
    rpt_hit = (REPEAT_FRAMES != 0) && level && frame_tick &&
              (rpt_cnt == RPT_W'(REPEAT_FRAMES - 1));
  end

  // Two-flop synchroniser for the raw pin.
  always_ff @(posedge clkvideo or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= btn;
      btn_sync <= btn_meta;
    end
  end

  // Accept a new level only after it has held for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clkvideo or negedge rst_n) begin
    if (!rst_n) begin
      level  <= 1'b0;
      db_cnt <= '0;
    end else if (btn_sync == level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      level  <= btn_sync;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 20'd1;
    end
  end

  // Count frames while held; wrap and fire a repeat at REPEAT_FRAMES.
  always_ff @(posedge clkvideo or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt <= '0;
    end else if (!level) begin
      rpt_cnt <= '0;
    end else if (frame_tick && (REPEAT_FRAMES != 0)) begin
      rpt_cnt <= rpt_hit ? '0 : rpt_cnt + 8'd1;
    end
  end

  // Registered step: press edge or auto-repeat expiry.
  always_ff @(posedge clkvideo or negedge rst_n) begin
    if (!rst_n) begin
      level_d <= 1'b0;
      step    <= 1'b0;
    end else begin
      level_d <= level;
      step    <= rise | rpt_hit;
    end
  end

endmodule

// File: rtl/vmode_sequencer.sv
// Palette mode selector: two debounced buttons step the mode, and the
// new mode is committed only on a vsync frame boundary.
module vmode_sequencer
  import vmode_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned NUM_MODES       = NUM_MODES_DEFAULT,
  parameter int unsigned DEFAULT_MODE    = 0,
  parameter int unsigned REPEAT_FRAMES   = 30
) (
  input  logic               clkvideo,
  input  logic               rst_n,
  input  logic               btn_next,
  input  logic               btn_prev,
  input  logic               vsync,
  output logic [VMODE_W-1:0] vmode,
  output logic               mode_changed
);

  logic       vs_meta;
  logic       vs_sync;
  logic       vs_prev;
  logic       frame_tick;
  logic       step_next;
  logic       step_prev;
  req_state_e state;
  dir_e       dir;

  // Synchronise vsync and register its rising edge as the frame tick.
  always_ff @(posedge clkvideo or negedge rst_n) begin
    if (!rst_n) begin
      vs_meta    <= 1'b0;
      vs_sync    <= 1'b0;
      vs_prev    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vs_meta    <= vsync;
      vs_sync    <= vs_meta;
      vs_prev    <= vs_sync;
      frame_tick <= vs_sync & ~vs_prev;
    end
  end

  vmode_button #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_FRAMES   (REPEAT_FRAMES)
  ) u_btn_next (
    .clkvideo   (clkvideo),
    .rst_n      (rst_n),
    .btn        (btn_next),
    .frame_tick (frame_tick),
    .step       (step_next)
  );

  vmode_button #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_FRAMES   (REPEAT_FRAMES)
  ) u_btn_prev (
    .clkvideo   (clkvideo),
    .rst_n      (rst_n),
    .btn        (btn_prev),
    .frame_tick (frame_tick),
    .step       (step_prev)
  );

  // Latch one request per frame and commit it on the next frame tick.
  always_ff @(posedge clkvideo or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      dir          <= DIR_NEXT;
      vmode        <= VMODE_W'(DEFAULT_MODE);
      mode_changed <= 1'b0;
    end else begin
      mode_changed <= 1'b0;
      case (state)
        IDLE: begin
          if (step_next ^ step_prev) begin
            dir   <= step_next ? DIR_NEXT : DIR_PREV;
            state <= PENDING;
          end
        end
        PENDING: begin
          if (frame_tick) begin
            vmode        <= step_mode(vmode, dir, NUM_MODES);
            mode_changed <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
